// File: rtl/store_ctrl.sv
// ---------------------------------------------------------------------------
// store_ctrl
//
// Write-side capture controller for the phase-noise sample FIFO. When started,
// it takes a programmed number of samples from the measurement datapath and
// pushes them into the sample FIFO. For each word it generates the write
// address and tracks the written count. When the FIFO cannot take a valid
// sample, the sample is lost and an event pulse reports it.
//
// Parameters:
//   BASE_ADDR       address of FIFO entry 0
//   ADDR_WIDTH      width of wr_addr
//   DATA_WIDTH      sample / FIFO word width
//   FIFO_SIZE       FIFO depth in words (upper bound for a capture)
//   FIFO_SIZE_WIDTH counter width, must be able to hold FIFO_SIZE
//
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   start, abort            1-cycle control pulses
//   capture_len             samples to write, sampled on an accepted start
//   sample_in/_vld          datapath sample and its valid qualifier
//   fifo_rdy                FIFO can take one word this cycle
//   fifo_data/fifo_wr_en    FIFO write port (one word per high cycle)
//   wr_addr                 address of the word on fifo_data
//   wr_count                words written in the current/last capture
//   busy                    high while capturing
//   done                    1-cycle pulse when a capture completes
//   event_sample_dropped    1-cycle pulse, valid sample lost (FIFO full)
//   event_start_while_busy  1-cycle pulse, start ignored
//
// Build option:
//   STORE_CTRL_DROP_CNT_EN  adds a saturating 16-bit drop_count output
// ---------------------------------------------------------------------------
module store_ctrl #(
    parameter int                    ADDR_WIDTH      = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    FIFO_SIZE       = 1024,
    parameter int                    FIFO_SIZE_WIDTH = $clog2(FIFO_SIZE) + 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic                       abort,
    input  logic [FIFO_SIZE_WIDTH-1:0] capture_len,
    input  logic [DATA_WIDTH-1:0]      sample_in,
    input  logic                       sample_in_vld,
    input  logic                       fifo_rdy,
    output logic [DATA_WIDTH-1:0]      fifo_data,
    output logic                       fifo_wr_en,
    output logic [ADDR_WIDTH-1:0]      wr_addr,
    output logic [FIFO_SIZE_WIDTH-1:0] wr_count,
    output logic                       busy,
    output logic                       done,
    output logic                       event_sample_dropped,
`ifdef STORE_CTRL_DROP_CNT_EN
    output logic [15:0]                drop_count,
`endif
    output logic                       event_start_while_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [FIFO_SIZE_WIDTH-1:0] FIFO_SIZE_W    = FIFO_SIZE_WIDTH'(FIFO_SIZE);
    localparam logic [ADDR_WIDTH-1:0]      BYTES_PER_WORD = ADDR_WIDTH'(DATA_WIDTH / 8);

    state_t                     state;
    logic [FIFO_SIZE_WIDTH-1:0] target;
    logic [FIFO_SIZE_WIDTH-1:0] clamped_len;
    logic [FIFO_SIZE_WIDTH-1:0] count_inc;
    logic [ADDR_WIDTH-1:0]      word_addr;

    // A capture never asks for more words than the FIFO holds.
    assign clamped_len = (capture_len > FIFO_SIZE_W) ? FIFO_SIZE_W : capture_len;
    assign count_inc   = wr_count + FIFO_SIZE_WIDTH'(1);
    // Address of the word being written now, i.e. indexed by the pre-increment
    // count; the sum wraps naturally at ADDR_WIDTH.
    assign word_addr   = BASE_ADDR + ADDR_WIDTH'(wr_count) * BYTES_PER_WORD;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: every output register, data and address included, is reset so the
            // FIFO side sees clean zeros and an in-flight write is discarded.
            state                  <= IDLE;
            target                 <= '0;
            fifo_data              <= '0;
            fifo_wr_en             <= 1'b0;
            wr_addr                <= '0;
            wr_count               <= '0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            event_sample_dropped   <= 1'b0;
            event_start_while_busy <= 1'b0;
`ifdef STORE_CTRL_DROP_CNT_EN
            drop_count             <= '0;
`endif
        end else begin
            // NOTE: pulse outputs default low each cycle; the state branches below
            // only raise them, so each pulse lasts exactly one cycle.
            fifo_wr_en             <= 1'b0;
            done                   <= 1'b0;
            event_sample_dropped   <= 1'b0;
            event_start_while_busy <= 1'b0;

            if (abort) begin
                // Abort overrides everything: no write, no done, count is kept.
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            target   <= clamped_len;
                            wr_count <= '0;
`ifdef STORE_CTRL_DROP_CNT_EN
                            drop_count <= '0;
`endif
                            if (clamped_len == '0) begin
                                state <= DONE;
                                busy  <= 1'b0;
                            end else begin
                                state <= CAPTURE;
                                busy  <= 1'b1;
                            end
                        end
                    end

                    CAPTURE: begin
                        if (start) begin
                            event_start_while_busy <= 1'b1;
                        end
                        if (sample_in_vld) begin
                            if (fifo_rdy) begin
                                fifo_data  <= sample_in;
                                fifo_wr_en <= 1'b1;
                                wr_addr    <= word_addr;
                                wr_count   <= count_inc;
                                if (count_inc == target) begin
                                    state <= DONE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                event_sample_dropped <= 1'b1;
`ifdef STORE_CTRL_DROP_CNT_EN
                                if (drop_count != 16'hFFFF) begin
                                    drop_count <= drop_count + 16'd1;
                                end
`endif
                            end
                        end
                    end

                    DONE: begin
                        if (start) begin
                            event_start_while_busy <= 1'b1;
                        end
                        done  <= 1'b1;
                        state <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
